// File: rtl/csa_sum_sequencer.sv
// Multi-operand summation controller: streams 1..MAX_OPS operands, packs them
// into groups of four, reduces each group through a 4x32 carry-save adder and
// accumulates the group results into a wide sum register.

// 4x32 carry-save adder: two 3:2 compressor layers followed by one carry-propagate add.
module multiple_adder_csa_4x32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    input  logic [31:0] w,
    output logic [34:0] final_sum
);
    logic [31:0] w_s1;
    logic [32:0] w_c1;
    logic [32:0] w_a2;
    logic [32:0] w_w2;
    logic [32:0] w_s2;
    logic [33:0] w_c2;

    // First compressor layer over x, y, z; second folds in w.
    always_comb begin
        w_s1 = x ^ y ^ z;
        w_c1 = {((x & y) | (x & z) | (y & z)), 1'b0};
        w_a2 = {1'b0, w_s1};
        w_w2 = {1'b0, w};
        w_s2 = w_a2 ^ w_c1 ^ w_w2;
        w_c2 = {((w_a2 & w_c1) | (w_a2 & w_w2) | (w_c1 & w_w2)), 1'b0};
        final_sum = {2'b00, w_s2} + {1'b0, w_c2};
    end
endmodule

module csa_sum_sequencer #(
    parameter int unsigned MAX_OPS = 64,
    parameter int unsigned ACC_W   = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(MAX_OPS):0]     num_ops,
    input  logic                         op_valid,
    input  logic [31:0]                  op_data,
    output logic                         op_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [ACC_W-1:0]             sum
);
    localparam int unsigned NW = $clog2(MAX_OPS) + 1;
    localparam logic [NW-1:0] MaxOpsW = NW'(MAX_OPS);

    typedef enum logic [1:0] {StIdle, StLoad, StAdd, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [31:0]      r_slot [4];
    logic [1:0]       r_cnt;
    logic [NW-1:0]    r_rem;
    logic [ACC_W-1:0] r_sum;
    logic             r_done;
    logic             r_err;

    logic             w_legal;
    logic             w_accept;
    logic             w_group_full;
    logic [34:0]      w_csa_sum;

    multiple_adder_csa_4x32 u_csa (
        .x         (r_slot[0]),
        .y         (r_slot[1]),
        .z         (r_slot[2]),
        .w         (r_slot[3]),
        .final_sum (w_csa_sum)
    );

    // Decode handshake and group-complete conditions from state and counters.
    always_comb begin
        op_ready     = (r_state == StLoad);
        busy         = (r_state != StIdle);
        w_legal      = (num_ops != '0) && (num_ops <= MaxOpsW);
        w_accept     = op_valid && op_ready;
        // Group closes on the fourth slot or on the job's final operand.
        w_group_full = w_accept && ((r_cnt == 2'd3) || (r_rem == NW'(1)));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (start && w_legal) w_state_next = StLoad;
            StLoad: if (w_group_full) w_state_next = StAdd;
            StAdd:  w_state_next = (r_rem == '0) ? StDone : StLoad;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operand slots, counters, accumulator and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_slot[i] <= '0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_sum  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_state == StAdd) && (r_rem == '0);
            r_err  <= (r_state == StIdle) && start && !w_legal;
            case (r_state)
                StIdle: begin
                    if (start && w_legal) begin
                        r_rem <= num_ops;
                        r_sum <= '0;
                        r_cnt <= '0;
                        for (int i = 0; i < 4; i++) r_slot[i] <= '0;
                    end
                end
                StLoad: begin
                    if (w_accept) begin
                        r_slot[r_cnt] <= op_data;
                        r_cnt         <= r_cnt + 2'd1;
                        r_rem         <= r_rem - NW'(1);
                    end
                end
                StAdd: begin
                    // Unfilled slots stay zero, so a short final group adds correctly.
                    r_sum <= r_sum + ACC_W'(w_csa_sum);
                    r_cnt <= '0;
                    for (int i = 0; i < 4; i++) r_slot[i] <= '0;
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign err  = r_err;
    assign sum  = r_sum;
endmodule

// File: tb/tb_csa_sum_sequencer.sv
// Directed bench for csa_sum_sequencer: latency, sums, illegal/ignored starts, reset abort.
module tb_csa_sum_sequencer;
    localparam int NW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] num_ops;
    logic          op_valid;
    logic [31:0]   op_data;
    logic          op_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [39:0]   sum;

    int checks = 0;
    int errors = 0;
    logic [31:0] ops [64];

    csa_sum_sequencer #(.MAX_OPS(64), .ACC_W(40)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_ops  (num_ops),
        .op_valid (op_valid),
        .op_data  (op_data),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sum      (sum)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one job from a start at the next negedge; cycle 0 is the start-accept cycle.
    task automatic run_job(input int n, input int bubble_mod, input int mid_start_cyc,
                           output int done_cyc, output int bubbles, output int first_ready,
                           output int ready_cnt, output logic err_seen);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        done_cyc = -1;
        bubbles = 0;
        first_ready = -1;
        ready_cnt = 0;
        err_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        num_ops = NW'(n);
        op_valid = 1'b0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (cyc == mid_start_cyc);
            if (cyc == mid_start_cyc) num_ops = '0;
            if (err) err_seen = 1'b1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (op_ready) begin
                ready_cnt++;
                if (first_ready < 0) first_ready = cyc;
            end
            if (idx < n && !(bubble_mod > 0 && (cyc % bubble_mod) == 0)) begin
                op_valid = 1'b1;
                op_data = ops[idx];
                if (op_ready) idx++;
            end else begin
                op_valid = 1'b0;
                if (op_ready) bubbles++;
            end
        end
        start = 1'b0;
        op_valid = 1'b0;
    endtask

    // Checks the cycle after done: pulse gone, idle, sum held.
    task automatic check_after(input string tag, input logic [63:0] exp_sum);
        @(negedge clk);
        check({tag, "_done_low"}, {63'd0, done}, 64'd0);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        check({tag, "_sum_hold"}, {24'd0, sum}, exp_sum);
    endtask

    initial begin
        int dc, bub, fr, rc;
        logic es;

        rst_n = 1'b0;
        start = 1'b0;
        num_ops = '0;
        op_valid = 1'b0;
        op_data = '0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, op_ready}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_sum", {24'd0, sum}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Small four-operand job.
        ops[0] = 32'h3; ops[1] = 32'hA; ops[2] = 32'h1; ops[3] = 32'h2;
        run_job(4, 0, -1, dc, bub, fr, rc, es);
        check("j1_done_cyc", 64'(dc), 64'd6);
        check("j1_first_ready", 64'(fr), 64'd1);
        check("j1_ready_cnt", 64'(rc), 64'd4);
        check("j1_sum", {24'd0, sum}, 64'h10);
        check_after("j1", 64'h10);

        // Alternating bit patterns.
        ops[0] = 32'hAAAAAAAA; ops[1] = 32'h55555555;
        ops[2] = 32'hAAAAAAAA; ops[3] = 32'h55555555;
        run_job(4, 0, -1, dc, bub, fr, rc, es);
        check("j2_done_cyc", 64'(dc), 64'd6);
        check("j2_sum", {24'd0, sum}, 64'h1FFFFFFFE);

        // Partial group: z and w zero-filled.
        ops[0] = 32'hFFFFFFFF; ops[1] = 32'h00000001;
        run_job(2, 0, -1, dc, bub, fr, rc, es);
        check("j3_done_cyc", 64'(dc), 64'd4);
        check("j3_sum", {24'd0, sum}, 64'h100000000);
        check_after("j3", 64'h100000000);

        // Full-size job, back-to-back.
        for (int i = 0; i < 64; i++) ops[i] = 32'hFFFFFFFF;
        run_job(64, 0, -1, dc, bub, fr, rc, es);
        check("j4_done_cyc", 64'(dc), 64'd81);
        check("j4_sum", {24'd0, sum}, 64'h3FFFFFFFC0);

        // Same job with a bubble every third cycle.
        run_job(64, 3, -1, dc, bub, fr, rc, es);
        check("j5_has_bubbles", {63'd0, bub > 0}, 64'd1);
        check("j5_done_cyc", 64'(dc), 64'(81 + bub));
        check("j5_sum", {24'd0, sum}, 64'h3FFFFFFFC0);

        // Illegal num_ops=0: err pulse, stays idle, sum unchanged.
        @(negedge clk);
        start = 1'b1;
        num_ops = 7'd0;
        @(negedge clk);
        start = 1'b0;
        check("ill0_err", {63'd0, err}, 64'd1);
        check("ill0_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("ill0_err_pulse", {63'd0, err}, 64'd0);
        check("ill0_sum", {24'd0, sum}, 64'h3FFFFFFFC0);

        // Illegal num_ops=65.
        start = 1'b1;
        num_ops = 7'd65;
        @(negedge clk);
        start = 1'b0;
        check("ill65_err", {63'd0, err}, 64'd1);
        check("ill65_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("ill65_err_pulse", {63'd0, err}, 64'd0);
        check("ill65_sum", {24'd0, sum}, 64'h3FFFFFFFC0);

        // Start pulsed mid-job (with an illegal count) is ignored.
        ops[0] = 32'h3; ops[1] = 32'hA; ops[2] = 32'h1; ops[3] = 32'h2;
        run_job(4, 0, 2, dc, bub, fr, rc, es);
        check("mid_done_cyc", 64'(dc), 64'd6);
        check("mid_sum", {24'd0, sum}, 64'h10);
        check("mid_no_err", {63'd0, es}, 64'd0);

        // Reset during LOAD of a six-operand job, after one group has been added.
        for (int i = 0; i < 6; i++) ops[i] = 32'(16 * (i + 1));
        @(negedge clk);
        start = 1'b1;
        num_ops = 7'd6;
        @(negedge clk);
        start = 1'b0;
        op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_data = ops[i];
            @(negedge clk);
        end
        op_valid = 1'b0;
        check("rj_in_add", {63'd0, op_ready}, 64'd0);
        @(negedge clk);
        check("rj_partial_sum", {24'd0, sum}, 64'hA0);
        op_valid = 1'b1;
        op_data = ops[4];
        @(negedge clk);
        op_valid = 1'b0;
        check("rj_loading", {63'd0, op_ready}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rj_busy", {63'd0, busy}, 64'd0);
        check("rj_ready", {63'd0, op_ready}, 64'd0);
        check("rj_sum", {24'd0, sum}, 64'd0);
        check("rj_err", {63'd0, err}, 64'd0);
        es = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) es = 1'b1;
        end
        check("rj_no_done", {63'd0, es}, 64'd0);
        rst_n = 1'b1;

        // Single-operand job after reset.
        ops[0] = 32'h7;
        run_job(1, 0, -1, dc, bub, fr, rc, es);
        check("j6_done_cyc", 64'(dc), 64'd3);
        check("j6_sum", {24'd0, sum}, 64'h7);
        check_after("j6", 64'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
